// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: inter-stage FIFO buffer that responds to both the writer and the reader
// handshakes, and can be flushed from the jump/branch path.
//   clk, rst                 clock and synchronous active-high reset
//   flush                    drops all entries and any request held across it
//   buf_we/buf_din/buf_wack  writer request, payload and one-cycle accept pulse
//   buf_re/buf_dout/buf_rack reader request, registered payload and one-cycle accept pulse
//   buf_avail, buf_count     registered non-empty flag and occupancy (0..DEPTH)
module pipe_stage_buf #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned AW    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             buf_we,
  input  logic [WIDTH-1:0] buf_din,
  output logic             buf_wack,
  output logic             buf_avail,
  input  logic             buf_re,
  output logic [WIDTH-1:0] buf_dout,
  output logic             buf_rack,
  output logic [AW:0]      buf_count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             wr_armed, rd_armed;
  logic             full_c, empty_c, wr_acc_c, rd_acc_c;
  logic [AW:0]      count_nxt_c;

  // Accept decisions use the pre-edge occupancy; there is no write-to-read bypass.
  always_comb begin
    full_c      = (buf_count == (AW+1)'(DEPTH));
    empty_c     = (buf_count == '0);
    wr_acc_c    = buf_we && wr_armed && !full_c && !flush;
    rd_acc_c    = buf_re && rd_armed && !empty_c && !flush;
    count_nxt_c = buf_count;
    if (wr_acc_c && !rd_acc_c) begin
      count_nxt_c = buf_count + (AW+1)'(1);
    end else if (rd_acc_c && !wr_acc_c) begin
      count_nxt_c = buf_count - (AW+1)'(1);
    end
  end

  // Storage array: contents need no reset.
  always_ff @(posedge clk) begin
    if (wr_acc_c && !rst) begin
      mem[wr_ptr] <= buf_din;
    end
  end

  // Control, pointers, handshake pulses and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      wr_armed  <= 1'b1;
      rd_armed  <= 1'b1;
      buf_wack  <= 1'b0;
      buf_rack  <= 1'b0;
      buf_avail <= 1'b0;
      buf_dout  <= '0;
      buf_count <= '0;
    end else if (flush) begin
      // Disarm both sides so a request held across the flush must be re-raised.
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      wr_armed  <= 1'b0;
      rd_armed  <= 1'b0;
      buf_wack  <= 1'b0;
      buf_rack  <= 1'b0;
      buf_avail <= 1'b0;
      buf_count <= '0;
    end else begin
      buf_wack  <= wr_acc_c;
      buf_rack  <= rd_acc_c;
      buf_count <= count_nxt_c;
      buf_avail <= (count_nxt_c != '0);
      if (wr_acc_c) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_acc_c) begin
        rd_ptr   <= rd_ptr + AW'(1);
        buf_dout <= mem[rd_ptr];
      end
      // One entry per request: disarm on accept, re-arm only once the request drops.
      if (!buf_we) begin
        wr_armed <= 1'b1;
      end else if (wr_acc_c) begin
        wr_armed <= 1'b0;
      end
      if (!buf_re) begin
        rd_armed <= 1'b1;
      end else if (rd_acc_c) begin
        rd_armed <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: directed scoreboard bench for pipe_stage_buf (WIDTH=32, DEPTH=2).
module tb_pipe_stage_buf;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned AW    = 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             buf_we;
  logic [WIDTH-1:0] buf_din;
  logic             buf_wack;
  logic             buf_avail;
  logic             buf_re;
  logic [WIDTH-1:0] buf_dout;
  logic             buf_rack;
  logic [AW:0]      buf_count;

  int total = 0;
  int bad   = 0;
  logic [WIDTH-1:0] sb [$];
  logic prev_wack = 1'b0;
  logic prev_rack = 1'b0;

  pipe_stage_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .buf_we(buf_we), .buf_din(buf_din), .buf_wack(buf_wack), .buf_avail(buf_avail),
    .buf_re(buf_re), .buf_dout(buf_dout), .buf_rack(buf_rack), .buf_count(buf_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Writer: hold we until wack, record the payload in the scoreboard, then one idle cycle.
  task automatic do_write(input logic [WIDTH-1:0] d);
    logic seen = 1'b0;
    buf_din = d;
    buf_we  = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (buf_wack) begin
        seen = 1'b1;
        sb.push_back(d);
      end
    end
    chk("wack_seen", WIDTH'(seen), WIDTH'(1));
    buf_we = 1'b0;
    @(negedge clk);
    chk("wack_pulse", WIDTH'(buf_wack), WIDTH'(0));
  endtask

  // Reader: hold re until rack, compare dout against the scoreboard head, then one idle cycle.
  task automatic do_read();
    logic seen = 1'b0;
    logic [WIDTH-1:0] exp;
    buf_re = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (buf_rack) begin
        seen = 1'b1;
        exp  = (sb.size() > 0) ? sb.pop_front() : 'x;
        chk("read_data", buf_dout, exp);
      end
    end
    chk("rack_seen", WIDTH'(seen), WIDTH'(1));
    buf_re = 1'b0;
    @(negedge clk);
    chk("rack_pulse", WIDTH'(buf_rack), WIDTH'(0));
  endtask

  // Invariants checked every cycle out of reset.
  always @(negedge clk) begin
    if (!rst) begin
      chk("wack_consec", WIDTH'(prev_wack && buf_wack), WIDTH'(0));
      chk("rack_consec", WIDTH'(prev_rack && buf_rack), WIDTH'(0));
      chk("count_bound", WIDTH'(buf_count > (AW+1)'(DEPTH)), WIDTH'(0));
    end
    prev_wack <= buf_wack;
    prev_rack <= buf_rack;
  end

  initial begin
    int n;
    rst = 1'b1; flush = 1'b0; buf_we = 1'b0; buf_re = 1'b0; buf_din = '0;
    repeat (2) @(negedge clk);
    chk("rst_wack",  WIDTH'(buf_wack),  WIDTH'(0));
    chk("rst_rack",  WIDTH'(buf_rack),  WIDTH'(0));
    chk("rst_avail", WIDTH'(buf_avail), WIDTH'(0));
    chk("rst_dout",  buf_dout,          WIDTH'(0));
    chk("rst_count", WIDTH'(buf_count), WIDTH'(0));
    rst = 1'b0;
    @(negedge clk);

    // Single transfer.
    do_write(32'hAA);
    chk("t1_avail", WIDTH'(buf_avail), WIDTH'(1));
    chk("t1_count", WIDTH'(buf_count), WIDTH'(1));
    do_read();
    chk("t1_avail_after", WIDTH'(buf_avail), WIDTH'(0));
    chk("t1_count_after", WIDTH'(buf_count), WIDTH'(0));

    // Fill and overflow: the third write waits until a read has popped.
    do_write(32'h11);
    do_write(32'h22);
    chk("t2_count_full", WIDTH'(buf_count), WIDTH'(2));
    buf_din = 32'h33;
    buf_we  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t2_no_wack_full", WIDTH'(buf_wack), WIDTH'(0));
    end
    buf_re = 1'b1;
    @(negedge clk);
    chk("t2_rack", WIDTH'(buf_rack), WIDTH'(1));
    chk("t2_wack_same_edge", WIDTH'(buf_wack), WIDTH'(0));
    chk("t2_dout_first", buf_dout, sb.pop_front());
    buf_re = 1'b0;
    @(negedge clk);
    chk("t2_wack_next_edge", WIDTH'(buf_wack), WIDTH'(1));
    if (buf_wack) sb.push_back(32'h33);
    buf_we = 1'b0;
    @(negedge clk);
    do_read();
    do_read();
    chk("t2_count_end", WIDTH'(buf_count), WIDTH'(0));

    // Held requests produce exactly one entry and one read.
    buf_din = 32'h55;
    buf_we  = 1'b1;
    n = 0;
    repeat (5) begin
      @(negedge clk);
      if (buf_wack) begin n++; sb.push_back(32'h55); end
    end
    buf_we = 1'b0;
    chk("t3_wack_count", WIDTH'(n), WIDTH'(1));
    chk("t3_count", WIDTH'(buf_count), WIDTH'(1));
    @(negedge clk);
    buf_re = 1'b1;
    n = 0;
    repeat (5) begin
      @(negedge clk);
      if (buf_rack) begin n++; chk("t3_dout", buf_dout, sb.pop_front()); end
    end
    buf_re = 1'b0;
    chk("t3_rack_count", WIDTH'(n), WIDTH'(1));
    @(negedge clk);

    // Read and write raised together while empty: no bypass.
    buf_din = 32'h77;
    buf_we  = 1'b1;
    buf_re  = 1'b1;
    @(negedge clk);
    chk("t4_wack_e1", WIDTH'(buf_wack), WIDTH'(1));
    chk("t4_no_rack_e1", WIDTH'(buf_rack), WIDTH'(0));
    if (buf_wack) sb.push_back(32'h77);
    buf_we = 1'b0;
    @(negedge clk);
    chk("t4_rack_e2", WIDTH'(buf_rack), WIDTH'(1));
    if (buf_rack) chk("t4_dout", buf_dout, sb.pop_front());
    buf_re = 1'b0;
    @(negedge clk);
    chk("t4_count", WIDTH'(buf_count), WIDTH'(0));

    // Wrap-around.
    for (int i = 1; i <= 6; i++) begin
      do_write(WIDTH'(i));
      chk("t5_count", WIDTH'(buf_count), WIDTH'(1));
      do_read();
    end

    // Flush with a read held across it.
    do_write(32'hA1);
    do_write(32'hA2);
    buf_re = 1'b1;
    flush  = 1'b1;
    @(negedge clk);
    chk("t6_no_rack_flush", WIDTH'(buf_rack), WIDTH'(0));
    chk("t6_avail", WIDTH'(buf_avail), WIDTH'(0));
    chk("t6_count", WIDTH'(buf_count), WIDTH'(0));
    flush = 1'b0;
    sb.delete();
    @(negedge clk);
    do_write(32'hB0);
    repeat (3) begin
      @(negedge clk);
      chk("t6_held_re_blocked", WIDTH'(buf_rack), WIDTH'(0));
    end
    chk("t6_avail_b0", WIDTH'(buf_avail), WIDTH'(1));
    buf_re = 1'b0;
    @(negedge clk);
    do_read();
    chk("t6_sb_empty", WIDTH'(sb.size()), WIDTH'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound so the bench never hangs.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Inter-stage buffer between a producing pipeline stage (writer) and a consuming stage (reader).
- It is the responder on both buffer handshakes:
  - Writer side: acknowledges the writer's `we` request with a one-cycle `wack` pulse.
  - Reader side: advertises `avail`, and answers the reader's `re` request with data plus a one-cycle `rack` pulse.
- Holds up to DEPTH entries in FIFO order.
- Supports a flush from the jump/branch path.

Parameters:
- WIDTH, 32: payload width in bits (packed stage bundle).
- DEPTH, 2: number of entries. Must be a power of two, ≥2.
- AW, 1: pointer width, equal to log2(DEPTH).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard all entries and pending handshakes.
- buf_we  in  1  writer request, held high until buf_wack is seen.
- buf_din  in  WIDTH  write payload, stable while buf_we=1.
- buf_wack  out  1  one-cycle write-accept pulse.
- buf_avail  out  1  buffer non-empty.
- buf_re  in  1  reader request, held high until buf_rack is seen.
- buf_dout  out  WIDTH  read payload, registered and valid from the buf_rack cycle onward.
- buf_rack  out  1  one-cycle read-accept pulse.
- buf_count  out  AW+1  current occupancy, 0..DEPTH.

Behaviour:

Reset (synchronous):
- buf_wack=0, buf_rack=0, buf_avail=0, buf_dout=0, buf_count=0.
- Pointers=0; wr_armed=1; rd_armed=1.
- Storage contents are don't-care.

Storage:
- Circular array, wr_ptr and rd_ptr each AW bits, wrapping naturally DEPTH-1 → 0.
- count register AW+1 bits.
- full = (count==DEPTH); empty = (count==0).

Write accept:
- Condition: buf_we && wr_armed && !full && !flush. All terms are sampled at the edge and use pre-edge count.
- On accept:
  - mem[wr_ptr] <= buf_din.
  - wr_ptr++.
  - buf_wack <= 1 for exactly one cycle.
  - wr_armed <= 0.
- Re-arm: wr_armed <= 1 on any cycle where buf_we==0. Each `we` request therefore produces at most one entry, even if the writer holds `we` for extra cycles after the ack.

Read accept:
- Condition: buf_re && rd_armed && !empty && !flush, using pre-edge count.
- On accept:
  - buf_dout <= mem[rd_ptr].
  - rd_ptr++.
  - buf_rack <= 1 for exactly one cycle.
  - rd_armed <= 0.
- Re-arm: rd_armed <= 1 on any cycle where buf_re==0.
- buf_dout holds its value until the next read accept.

Simultaneous read and write in one cycle:
- Both may accept. count is unchanged.
- Full blocks a write even if a read pops in the same cycle.
- Empty blocks a read even if a write pushes in the same cycle. There is no bypass.

Outputs and latency:
- buf_avail = registered !empty, i.e. it reflects post-edge count.
- buf_count is registered.
- Write accepted at edge N → buf_avail=1 after edge N.
- Earliest read accept is edge N+1; buf_dout and buf_rack are valid after edge N+1.
- Minimum write-to-data latency is 2 edges.

Blocked requests:
- A blocked request (full, empty, or not armed) stays pending with no ack.
- It is accepted on the first edge where its condition becomes true.

Flush:
- Highest priority after rst.
- Sets count=0 and both pointers=0; buf_avail=0 after the edge.
- Suppresses any wack/rack on that edge; an ack pulse already high from the previous edge still drops normally.
- Sets both armed flags to 0. A request still held across the flush must be dropped and re-raised before it is accepted. No stale transaction survives a flush.
- buf_dout is unchanged.

Reset mid-transfer:
- Abandons all entries and pending requests; no ack is issued on the reset edge.

Invariants:
- count never exceeds DEPTH and never underflows.
- buf_wack and buf_rack are never high for two consecutive cycles.

Test Plan:
- Single transfer: reset, buf_we=1 with din=0x0000_00AA, drop we after wack; then buf_re=1 → wack pulse 1 cycle; avail=1, count=1; rack 1 cycle later with dout=0xAA; avail=0, count=0.
- Fill and overflow: write 0x11, 0x22, then a third with 0x33 held → first two acked; count=2; third gets no wack. Read once → dout=0x11; the 0x33 write is acked on the following edge (not the same edge); subsequent reads return 0x22 then 0x33.
- Held request: buf_we held high for 5 cycles with din=0x55 → exactly one wack, count=1. buf_re held 5 cycles → exactly one rack, dout=0x55.
- Empty read plus concurrent write: buf_re=1 and buf_we=1 (din=0x77) raised together while empty → wack at edge 1, no rack; rack at edge 2 with dout=0x77; count ends at 0.
- Wrap-around: 6 alternating write/read pairs with data 1..6 (DEPTH=2) → reads return 1..6 in order; pointers wrap; count never exceeds 2.
- Flush: fill with 0xA1, 0xA2; keep buf_re high and assert flush for 1 cycle → no rack on the flush edge; avail=0, count=0. The held re produces no rack until dropped and re-raised after a new write of 0xB0, which then returns dout=0xB0.
